// File: rtl/alu_exec_pkg.sv
// Shared constants for the registered execute stage: opcodes, operand
// source selects, CCR bit positions and the flag-update classes.
package alu_exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_SHL   = 4'h4;
  localparam logic [3:0] OP_SHR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_PASS2 = 4'h7;
  localparam logic [3:0] OP_INC   = 4'h8;
  localparam logic [3:0] OP_DEC   = 4'h9;
  localparam logic [3:0] OP_PASS1 = 4'hA;
  localparam logic [3:0] OP_SETC  = 4'hB;
  localparam logic [3:0] OP_CLRC  = 4'hC;
  localparam logic [3:0] OP_MUL   = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_NOP2  = 4'hF;

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_REG2 = 2'b11;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;

  // Which CCR bits an instruction writes
  typedef enum logic [1:0] {
    FU_NONE = 2'b00,
    FU_ZN   = 2'b01,
    FU_ZNC  = 2'b10,
    FU_C    = 2'b11
  } flag_upd_e;

endpackage

// File: rtl/alu_exec_if.sv
// ID/EX -> EX/MEM bundle of the execute stage. The master side (front end)
// drives operands and control; the slave side (execute unit) returns results.
interface alu_exec_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [3:0]       alu_op;
  logic             use_reg;
  logic [1:0]       sel_src;
  logic [1:0]       sel_dst;
  logic [WIDTH-1:0] reg_src;
  logic [WIDTH-1:0] reg_dst;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] fwd_ex;
  logic [WIDTH-1:0] fwd_mem;
  logic             flush;
  logic             flags_load;
  logic [2:0]       flags_in;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_op1;
  logic [2:0]       flags;
  logic             flags_wr;

  modport master (
    output in_valid, alu_op, use_reg, sel_src, sel_dst, reg_src, reg_dst, imm,
           fwd_ex, fwd_mem, flush, flags_load, flags_in,
    input  busy, out_valid, alu_result, alu_op1, flags, flags_wr
  );

  modport slave (
    input  in_valid, alu_op, use_reg, sel_src, sel_dst, reg_src, reg_dst, imm,
           fwd_ex, fwd_mem, flush, flags_load, flags_in,
    output busy, out_valid, alu_result, alu_op1, flags, flags_wr
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH
// iterations. o_done/o_product are valid during the last iteration cycle so
// the parent can register the result on the same edge busy drops.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  // Accumulator after adding the current partial product
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplier[0]) begin
      w_acc_nxt = r_acc + r_mcand;
    end else begin
      w_acc_nxt = r_acc;
    end
  end

  assign w_last = r_busy && (r_cnt == CW'(WIDTH - 1));

  // Load operands on start, iterate while busy, abort drops everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      r_busy   <= !w_last;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last && !i_abort;
  assign o_product = w_acc_nxt;
endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: operand forwarding/immediate select, ALU with
// SETC/CLRC, iterative MUL and an internal CCR (Z, N, C). Results, operand1
// and flags leave through one register stage.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  logic [WIDTH-1:0]   w_op1;
  logic [WIDTH-1:0]   w_op2;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH:0]     w_ext;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [SHW-1:0]     w_amt;
  logic               w_amt_zero;
  logic               w_amt_big;
  logic               w_c_new;
  flag_upd_e          w_fu;
  logic [2:0]         w_flags_alu;
  logic [2:0]         w_flags_mul;
  logic               w_accept;
  logic               w_issue_alu;
  logic               w_issue_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;

  logic               r_out_valid;
  logic               r_flags_wr;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_op1;
  logic [2:0]         r_flags;

  // Operand1 from register or forwarding paths; operand2 likewise or imm
  always_comb begin
    w_op1 = bus.reg_src;
    w_op2 = bus.imm;
    case (bus.sel_src)
      SEL_EX:  w_op1 = bus.fwd_ex;
      SEL_MEM: w_op1 = bus.fwd_mem;
      default: w_op1 = bus.reg_src;
    endcase
    if (bus.use_reg) begin
      case (bus.sel_dst)
        SEL_EX:  w_op2 = bus.fwd_ex;
        SEL_MEM: w_op2 = bus.fwd_mem;
        default: w_op2 = bus.reg_dst;
      endcase
    end else begin
      w_op2 = bus.imm;
    end
  end

  // Any set upper bit of op2 makes the shift at least 2**SHW, i.e. > WIDTH
  assign w_amt      = w_op2[SHW-1:0];
  assign w_amt_zero = (w_op2 == '0);
  assign w_amt_big  = ((w_op2 >> SHW) != '0) || (w_amt > SHW'(WIDTH));
  // One extra bit catches the last bit shifted out in either direction
  assign w_shl      = {1'b0, w_op1} << w_amt;
  assign w_shr      = {w_op1, 1'b0} >> w_amt;

  // Result, new carry and flag-update class of a single-cycle op
  always_comb begin
    w_res   = '0;
    w_ext   = '0;
    w_c_new = r_flags[FLG_C];
    w_fu    = FU_NONE;
    case (bus.alu_op)
      OP_ADD: begin
        w_ext = {1'b0, w_op1} + {1'b0, w_op2};
        w_res = w_ext[WIDTH-1:0]; w_c_new = w_ext[WIDTH]; w_fu = FU_ZNC;
      end
      OP_SUB: begin
        w_ext = {1'b0, w_op2} - {1'b0, w_op1};
        w_res = w_ext[WIDTH-1:0]; w_c_new = w_ext[WIDTH]; w_fu = FU_ZNC;
      end
      OP_AND: begin w_res = w_op1 & w_op2; w_fu = FU_ZN; end
      OP_OR:  begin w_res = w_op1 | w_op2; w_fu = FU_ZN; end
      OP_NOT: begin w_res = ~w_op1;        w_fu = FU_ZN; end
      OP_SHL, OP_SHR: begin
        w_fu = FU_ZNC;
        if (w_amt_zero) begin
          w_res = w_op1;
        end else if (w_amt_big) begin
          w_res = '0; w_c_new = 1'b0;
        end else if (bus.alu_op == OP_SHL) begin
          w_res = w_shl[WIDTH-1:0]; w_c_new = w_shl[WIDTH];
        end else begin
          w_res = w_shr[WIDTH:1]; w_c_new = w_shr[0];
        end
      end
      OP_PASS2: w_res = w_op2;
      OP_PASS1: w_res = w_op1;
      OP_INC: begin
        w_ext = {1'b0, w_op1} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_ext[WIDTH-1:0]; w_c_new = w_ext[WIDTH]; w_fu = FU_ZNC;
      end
      OP_DEC: begin
        w_ext = {1'b0, w_op1} - {{WIDTH{1'b0}}, 1'b1};
        w_res = w_ext[WIDTH-1:0]; w_c_new = w_ext[WIDTH]; w_fu = FU_ZNC;
      end
      OP_SETC: begin w_c_new = 1'b1; w_fu = FU_C; end
      OP_CLRC: begin w_c_new = 1'b0; w_fu = FU_C; end
      default: w_fu = FU_NONE;
    endcase
  end

  // CCR as left by the single-cycle op, per its update class
  always_comb begin
    w_flags_alu = r_flags;
    case (w_fu)
      FU_ZNC: begin
        w_flags_alu[FLG_Z] = (w_res == '0);
        w_flags_alu[FLG_N] = w_res[WIDTH-1];
        w_flags_alu[FLG_C] = w_c_new;
      end
      FU_ZN: begin
        w_flags_alu[FLG_Z] = (w_res == '0);
        w_flags_alu[FLG_N] = w_res[WIDTH-1];
      end
      FU_C:    w_flags_alu[FLG_C] = w_c_new;
      default: w_flags_alu = r_flags;
    endcase
  end

  assign w_flags_mul[FLG_Z] = (w_product[WIDTH-1:0] == '0);
  assign w_flags_mul[FLG_N] = w_product[WIDTH-1];
  assign w_flags_mul[FLG_C] = (w_product[2*WIDTH-1:WIDTH] != '0);

  // New instructions are refused while MUL runs; flush kills the one offered
  assign w_accept    = bus.in_valid && !w_mul_busy && !bus.flush;
  assign w_issue_mul = w_accept && (bus.alu_op == OP_MUL);
  assign w_issue_alu = w_accept && (bus.alu_op != OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_issue_mul),
    .i_abort   (bus.flush),
    .i_a       (w_op1),
    .i_b       (w_op2),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // EX/MEM boundary registers and the CCR; flags_load beats any update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_flags_wr  <= 1'b0;
      r_result    <= '0;
      r_op1       <= '0;
      r_flags     <= 3'b000;
    end else begin
      if (w_issue_alu) begin
        r_out_valid <= 1'b1;
        r_flags_wr  <= (w_fu != FU_NONE);
        r_result    <= w_res;
      end else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_flags_wr  <= 1'b1;
        r_result    <= w_product[WIDTH-1:0];
      end else begin
        r_out_valid <= 1'b0;
        r_flags_wr  <= 1'b0;
      end
      if (w_accept) begin
        r_op1 <= w_op1;
      end
      if (bus.flags_load) begin
        r_flags <= bus.flags_in;
      end else if (w_issue_alu) begin
        r_flags <= w_flags_alu;
      end else if (w_mul_done) begin
        r_flags <= w_flags_mul;
      end
    end
  end

  assign bus.busy       = w_mul_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.flags_wr   = r_flags_wr;
  assign bus.alu_result = r_result;
  assign bus.alu_op1    = r_op1;
  assign bus.flags      = r_flags;
endmodule
